// File: rtl/hsv_duty_gen.sv
// Hue (0..359 deg, full saturation/value) to RGB PWM duty converter.
// One shared restoring divider computes L*PWM_INTERVAL/60 per channel, serially.
module hsv_duty_gen #(
  parameter int PWM_INTERVAL = 1200,
  parameter int DUTY_W       = $clog2(PWM_INTERVAL+1),
  parameter int DIV_W        = $clog2(60*PWM_INTERVAL+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8:0]        in_hue,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DUTY_W-1:0] duty_r,
  output logic [DUTY_W-1:0] duty_g,
  output logic [DUTY_W-1:0] duty_b
);

  localparam int CNT_W = $clog2(DIV_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W-1);
  localparam logic [DIV_W-1:0] PWM_K    = DIV_W'(PWM_INTERVAL);

  typedef enum logic [2:0] {IDLE, SETUP, DIV_R, DIV_G, DIV_B, DONE} state_e;

  state_e state_q, state_d;

  logic [8:0]        hue_q;
  logic [6:0]        lg_q, lb_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DIV_W-1:0]  dvd_q;
  logic [6:0]        rem_q;
  logic [DUTY_W-1:0] quo_q;
  logic [DUTY_W-1:0] duty_r_q, duty_g_q, duty_b_q;

  function automatic logic [DIV_W-1:0] scale(input logic [6:0] l);
    return DIV_W'(l) * PWM_K;
  endfunction

  // Sector/fraction decode and per-channel levels (0..60)
  logic [2:0] sec;
  logic [8:0] base;
  logic [6:0] f, lvl_r, lvl_g, lvl_b;

  always_comb begin
    sec  = 3'd5;
    base = 9'd300;
    if      (hue_q < 9'd60)  begin sec = 3'd0; base = 9'd0;   end
    else if (hue_q < 9'd120) begin sec = 3'd1; base = 9'd60;  end
    else if (hue_q < 9'd180) begin sec = 3'd2; base = 9'd120; end
    else if (hue_q < 9'd240) begin sec = 3'd3; base = 9'd180; end
    else if (hue_q < 9'd300) begin sec = 3'd4; base = 9'd240; end
    f = 7'(hue_q - base);
    lvl_r = 7'd60; lvl_g = 7'd0; lvl_b = 7'd60 - f;
    case (sec)
      3'd0: begin lvl_r = 7'd60;     lvl_g = f;            lvl_b = 7'd0;  end
      3'd1: begin lvl_r = 7'd60 - f; lvl_g = 7'd60;        lvl_b = 7'd0;  end
      3'd2: begin lvl_r = 7'd0;      lvl_g = 7'd60;        lvl_b = f;     end
      3'd3: begin lvl_r = 7'd0;      lvl_g = 7'd60 - f;    lvl_b = 7'd60; end
      3'd4: begin lvl_r = f;         lvl_g = 7'd0;         lvl_b = 7'd60; end
      default: ;
    endcase
  end

  // One restoring-divide step: quotient bit per cycle, MSB first
  logic [7:0]        rem_sh;
  logic              ge;
  logic [6:0]        rem_nx;
  logic [DUTY_W-1:0] quo_nx;
  logic              div_last;

  always_comb begin
    rem_sh   = {rem_q, dvd_q[DIV_W-1]};
    ge       = rem_sh >= 8'd60;
    rem_nx   = ge ? 7'(rem_sh - 8'd60) : rem_sh[6:0];
    quo_nx   = DUTY_W'({quo_q, ge});
    div_last = cnt_q == CNT_LAST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = SETUP;
      SETUP:                  state_d = DIV_R;
      DIV_R:   if (div_last)  state_d = DIV_G;
      DIV_G:   if (div_last)  state_d = DIV_B;
      DIV_B:   if (div_last)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hue_q    <= '0;
      lg_q     <= '0;
      lb_q     <= '0;
      cnt_q    <= '0;
      dvd_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      duty_r_q <= '0;
      duty_g_q <= '0;
      duty_b_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) hue_q <= (in_hue >= 9'd360) ? in_hue - 9'd360 : in_hue;
        SETUP: begin
          lg_q  <= lvl_g;
          lb_q  <= lvl_b;
          dvd_q <= scale(lvl_r);
          rem_q <= '0;
          quo_q <= '0;
          cnt_q <= '0;
        end
        DIV_R, DIV_G, DIV_B: begin
          if (div_last) begin
            // Commit this channel and preload the next channel's dividend
            case (state_q)
              DIV_R:   begin duty_r_q <= quo_nx; dvd_q <= scale(lg_q); end
              DIV_G:   begin duty_g_q <= quo_nx; dvd_q <= scale(lb_q); end
              default: begin duty_b_q <= quo_nx; dvd_q <= '0;          end
            endcase
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
          end else begin
            dvd_q <= {dvd_q[DIV_W-2:0], 1'b0};
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign duty_r = duty_r_q;
  assign duty_g = duty_g_q;
  assign duty_b = duty_b_q;

endmodule
